rr_pri_enc: RTL and testbench
=============================

Name: rr_pri_enc

Overview:
- Registered, handshaked successor to the combinational priority encoder.
- Selects one active request from an IN-bit vector and presents its binary index plus a one-hot grant on a valid/ready output stage.
- MODE selects fixed priority (LSB- or MSB-first) or round-robin. In round-robin the search start rotates past the last accepted index.
- Sits in front of shared resources (issue ports, bus masters, free-list allocation) where the consumer can stall.

Parameters:
- IN, 32: request vector width; legal range >= 2, need not be a power of two.
- ACT, `HIGH: active level of in; `LOW means a 0 bit is a request.
- MODE, 1: 0 = fixed priority, 1 = round-robin.
- MSB, `ENABLE: fixed mode only; `ENABLE searches IN-1 downward, `DISABLE searches 0 upward. Ignored when MODE=1.
- OUT, $clog2(IN): index width; derived, not overridden.

Ports:
- clk, input, 1: clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous clear of the output stage and the pointer.
- in, input, IN: request vector, polarity set by ACT.
- out_valid, output, 1: registered index is valid; active high regardless of ACT.
- out_ready, input, 1: consumer accepts when out_valid && out_ready.
- out, output, OUT: registered index of the selected request.
- grant, output, IN: registered one-hot of out; all zero when out_valid=0.
- ptr, output, OUT: current round-robin search base, for debug and coverage; always 0 when MODE=0.

Behaviour:
- in_act = ACT ? in : ~in. All internal logic is active high.
- Reset (reset_n=0, asynchronous): out_valid=0, out=0, grant=0, ptr=0.
- Stage free: load_en = !out_valid || out_ready.
- Fire: fire = out_valid && out_ready.
- Search base:
  - MODE=1: base = fire ? nxt(out) : ptr, where nxt(i) = (i==IN-1) ? 0 : i+1. Using the bypass on fire keeps back-to-back grants from repeating an index.
  - MODE=0: the base is fixed at the end set by MSB.
- Selection (MODE=1): the first set bit of in_act scanning base, base+1, ..., IN-1, 0, ..., base-1 (circular).
- Selection (MODE=0): the first set bit from the MSB or LSB end, identical to the combinational encoder.
- Load when load_en=1:
  - out_valid <= |in_act.
  - If |in_act: out <= selected index, grant <= onehot(selected).
  - Else: out <= 0, grant <= 0.
- Hold when load_en=0: out, grant and out_valid are stable. Changes on in are ignored.
- Pointer (MODE=1): on fire, ptr <= nxt(out). Otherwise ptr holds. Non-power-of-two IN wraps at IN-1, never at 2^OUT-1.
- Latency: one cycle from in to out_valid/out when the stage is free. Full throughput, one grant per cycle while out_ready=1.
- flush=1: at the next edge out_valid=0, grant=0, out=0, ptr=0. flush has priority over load and over the fire-driven ptr update; that cycle's fire is discarded.
- Requests are level-sampled, not latched. A request that drops while a different grant is held is simply not seen at the next load.
- Fairness (MODE=1): with k requests held continuously and out_ready=1, each is granted exactly once per k consecutive grants.
- The block never asserts out_valid with grant=0, and never asserts grant with more than one bit set.

Test Plan:
- Reset/idle:
  - Stimulus: reset_n=0 for 3 cycles with in=all-ones, ACT=HIGH, then release with in=0.
  - Required: out_valid=0, grant=0, ptr=0 during reset and after release.
- Round-robin rotation:
  - Stimulus: IN=8, MODE=1, in=8'b1001_0110 held, out_ready=1.
  - Required: out sequence 1,2,4,7,1,2,... on consecutive cycles; ptr follows 2,3,5,0,2,...
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles after out=4 is presented, while in changes to 8'b0000_0001.
  - Required: out=4 and grant=8'h10 held stable.
  - On out_ready=1: the next cycle loads out=0, since the search from base 5 wraps to 0.
- Fixed priority and polarity:
  - Stimulus: MODE=0, MSB=`ENABLE, ACT=`LOW, in=8'b1101_1111.
  - Required: out=5, grant=8'h20, ptr=0.
  - With MSB=`DISABLE, same input: out=5.
  - With in=8'hFF: out_valid=0.
- Non-power-of-two wrap:
  - Stimulus: IN=5, MODE=1, in=5'b10001, out_ready=1.
  - Required: grants alternate 0,4,0,4; ptr never exceeds 4.
- Flush:
  - Stimulus: assert flush in the same cycle as a fire of out=6.
  - Required: next cycle out_valid=0, ptr=0. The following load searches from 0, not 7.

Source files
------------

// File: rtl/rr_pri_enc.sv
// Registered valid/ready priority encoder: fixed (LSB/MSB-first) or round-robin selection
// of one request, presented as a binary index plus a one-hot grant.
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

// One lane: qualifies its request by whether it lies at or above the search base.
module rr_pri_enc_lane #(
  parameter int OUT  = 3,
  parameter int LANE = 0
) (
  input  logic [OUT-1:0] base,
  input  logic           req,
  output logic           hi
);
  assign hi = req && (OUT'(LANE) >= base);
endmodule

module rr_pri_enc #(
  parameter int IN   = 32,
  parameter bit ACT  = `HIGH,
  parameter bit MODE = 1'b1,
  parameter bit MSB  = `ENABLE,
  parameter int OUT  = $clog2(IN)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  input  logic [IN-1:0]  in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OUT-1:0] out,
  output logic [IN-1:0]  grant,
  output logic [OUT-1:0] ptr
);
  localparam logic [OUT-1:0] LAST = OUT'(IN - 1);

  logic [IN-1:0]  in_act, req_hi, sel_oh;
  logic           load_en, fire, any;
  logic [OUT-1:0] nxt_out, base, sel;

  assign in_act  = ACT ? in : ~in;
  assign any     = |in_act;
  assign load_en = !out_valid || out_ready;
  assign fire    = out_valid && out_ready;
  // Wrap at IN-1 so non-power-of-two widths never visit unused indices.
  assign nxt_out = (out == LAST) ? '0 : out + 1'b1;
  // Bypass the pointer on fire so back-to-back grants never repeat an index.
  assign base    = (MODE && fire) ? nxt_out : ptr;

  genvar gi;
  generate
    for (gi = 0; gi < IN; gi++) begin : g_lane
      rr_pri_enc_lane #(.OUT(OUT), .LANE(gi)) u_lane (
        .base (base),
        .req  (in_act[gi]),
        .hi   (req_hi[gi])
      );
    end
  endgenerate

  function automatic logic [OUT-1:0] find_lo(input logic [IN-1:0] v);
    logic [OUT-1:0] r;
    r = '0;
    for (int i = IN - 1; i >= 0; i--)
      if (v[i]) r = OUT'(i);
    return r;
  endfunction

  function automatic logic [OUT-1:0] find_hi(input logic [IN-1:0] v);
    logic [OUT-1:0] r;
    r = '0;
    for (int i = 0; i < IN; i++)
      if (v[i]) r = OUT'(i);
    return r;
  endfunction

  // Circular search = lowest request at/above base, else lowest request overall.
  always_comb begin
    sel = '0;
    if (MODE)     sel = (|req_hi) ? find_lo(req_hi) : find_lo(in_act);
    else if (MSB) sel = find_hi(in_act);
    else          sel = find_lo(in_act);
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < IN; i++)
      sel_oh[i] = any && (sel == OUT'(i));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      grant     <= '0;
      ptr       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out       <= '0;
      grant     <= '0;
      ptr       <= '0;
    end else begin
      if (load_en) begin
        out_valid <= any;
        out       <= any ? sel : '0;
        grant     <= sel_oh;
      end
      if (MODE && fire) ptr <= nxt_out;
    end
  end
endmodule

// File: tb/tb_rr_pri_enc.sv
// Randomized + directed bench for rr_pri_enc: four configurations checked each cycle
// against a circular-scan reference model.
module tb_rr_pri_enc;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_v [4];
  logic       rdy  [4];
  logic       fl   [4];
  logic       vld  [4];
  logic [2:0] o    [4];
  logic [2:0] p    [4];
  logic [7:0] g    [4];
  logic [4:0] g3;

  // Instance configs: 0 rr IN=8 HIGH, 1 fixed MSB LOW, 2 fixed LSB LOW, 3 rr IN=5 HIGH
  int c_n    [4] = '{8, 8, 8, 5};
  bit c_act  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit c_mode [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit c_msb  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  int m_v [4];
  int m_o [4];
  int m_p [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_pri_enc #(.IN(8), .ACT(1'b1), .MODE(1'b1), .MSB(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .flush(fl[0]), .in(in_v[0]), .out_valid(vld[0]),
    .out_ready(rdy[0]), .out(o[0]), .grant(g[0]), .ptr(p[0]));
  rr_pri_enc #(.IN(8), .ACT(1'b0), .MODE(1'b0), .MSB(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .flush(fl[1]), .in(in_v[1]), .out_valid(vld[1]),
    .out_ready(rdy[1]), .out(o[1]), .grant(g[1]), .ptr(p[1]));
  rr_pri_enc #(.IN(8), .ACT(1'b0), .MODE(1'b0), .MSB(1'b0)) u2 (
    .clk(clk), .reset_n(reset_n), .flush(fl[2]), .in(in_v[2]), .out_valid(vld[2]),
    .out_ready(rdy[2]), .out(o[2]), .grant(g[2]), .ptr(p[2]));
  rr_pri_enc #(.IN(5), .ACT(1'b1), .MODE(1'b1), .MSB(1'b0)) u3 (
    .clk(clk), .reset_n(reset_n), .flush(fl[3]), .in(in_v[3][4:0]), .out_valid(vld[3]),
    .out_ready(rdy[3]), .out(o[3]), .grant(g3), .ptr(p[3]));
  assign g[3] = {3'b000, g3};

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  // Spec-level step: circular scan by modular arithmetic over integer indices.
  task automatic model_step(input int k);
    int n, act, base, sel, idx, old_o;
    bit fire, load;
    n     = c_n[k];
    act   = int'(c_act[k] ? in_v[k] : ~in_v[k]) & ((1 << n) - 1);
    fire  = (m_v[k] != 0) && rdy[k];
    load  = (m_v[k] == 0) || rdy[k];
    old_o = m_o[k];
    if (fl[k]) begin
      m_v[k] = 0; m_o[k] = 0; m_p[k] = 0;
      return;
    end
    if (c_mode[k]) base = fire ? (old_o + 1) % n : m_p[k];
    else           base = 0;
    sel = -1;
    for (int j = 0; j < n; j++) begin
      if (!c_mode[k] && c_msb[k]) idx = n - 1 - j;
      else                        idx = (base + j) % n;
      if (sel < 0 && act[idx]) sel = idx;
    end
    if (load) begin
      m_v[k] = (sel >= 0) ? 1 : 0;
      m_o[k] = (sel >= 0) ? sel : 0;
    end
    if (c_mode[k] && fire) m_p[k] = (old_o + 1) % n;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (!reset_n) begin
        m_v[k] = 0; m_o[k] = 0; m_p[k] = 0;
      end else model_step(k);
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("m%0d_vld", k),   int'(vld[k]), m_v[k]);
      chk($sformatf("m%0d_out", k),   int'(o[k]),   m_o[k]);
      chk($sformatf("m%0d_grant", k), int'(g[k]),   m_v[k] != 0 ? (1 << m_o[k]) : 0);
      chk($sformatf("m%0d_ptr", k),   int'(p[k]),   m_p[k]);
    end
  endtask

  int exp_o [5] = '{2, 4, 7, 1, 2};
  int exp_p [5] = '{2, 3, 5, 0, 2};

  initial begin
    for (int k = 0; k < 4; k++) begin
      in_v[k] = 8'hFF; rdy[k] = 1'b1; fl[k] = 1'b0;
      m_v[k] = 0; m_o[k] = 0; m_p[k] = 0;
    end
    repeat (3) tick();
    chk("rst_vld", int'(vld[0]), 0);
    chk("rst_grant", int'(g[0]), 0);
    chk("rst_ptr", int'(p[0]), 0);

    reset_n = 1'b1;
    in_v[0] = 8'h00; in_v[1] = 8'hFF; in_v[2] = 8'hFF; in_v[3] = 8'h00;
    tick();
    chk("idle_vld", int'(vld[0]), 0);
    chk("idle_grant", int'(g[0]), 0);
    chk("idle_ptr", int'(p[0]), 0);

    // Rotation, fixed priority with inverted polarity, and IN=5 wrap
    in_v[0] = 8'b1001_0110; in_v[1] = 8'b1101_1111; in_v[2] = 8'b1101_1111; in_v[3] = 8'b0001_0001;
    tick();
    chk("rr_first", int'(o[0]), 1);
    chk("fix_msb_out", int'(o[1]), 5);
    chk("fix_msb_grant", int'(g[1]), 8'h20);
    chk("fix_msb_ptr", int'(p[1]), 0);
    chk("fix_lsb_out", int'(o[2]), 5);
    chk("np2_first", int'(o[3]), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_out", int'(o[0]), exp_o[i]);
      chk("rr_ptr", int'(p[0]), exp_p[i]);
      chk("np2_out", int'(o[3]), (i % 2 == 0) ? 4 : 0);
      chk("np2_ptr_le4", int'(p[3] <= 3'd4), 1);
    end
    tick();
    chk("rr_out4", int'(o[0]), 4);
    chk("rr_ptr4", int'(p[0]), 3);

    // Backpressure: hold out=4 while in changes
    rdy[0] = 1'b0; in_v[0] = 8'h01; in_v[1] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_out", int'(o[0]), 4);
      chk("bp_grant", int'(g[0]), 8'h10);
    end
    chk("fix_none_vld", int'(vld[1]), 0);
    rdy[0] = 1'b1;
    tick();
    chk("bp_wrap_out", int'(o[0]), 0);
    chk("bp_wrap_ptr", int'(p[0]), 5);

    // Flush on the same edge as a fire of out=6
    in_v[0] = 8'h40;
    tick();
    chk("pre_flush_out", int'(o[0]), 6);
    fl[0] = 1'b1; in_v[0] = 8'h81;
    tick();
    chk("flush_vld", int'(vld[0]), 0);
    chk("flush_ptr", int'(p[0]), 0);
    fl[0] = 1'b0;
    tick();
    chk("post_flush_out", int'(o[0]), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 4; k++) begin
        in_v[k] = 8'($urandom) & ((c % 3 == 0) ? 8'($urandom) : 8'hFF);
        rdy[k]  = ($urandom_range(0, 3) != 0);
        fl[k]   = ($urandom_range(0, 31) == 0);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
